// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the burst SPI slave and its RAM.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    ADDR,
    WRITE,
    RD_WAIT,
    READ,
    IGNORE
  } state_t;

  localparam logic [1:0] OPC_WRITE = 2'b00;
  localparam logic [1:0] OPC_READ  = 2'b01;
  localparam int         DUMMY_BITS = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_ram_sp.sv
// Synchronous single-port RAM, one-cycle registered read, write-first.
module spi_ram_sp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
        r_rdata       <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave (one bit per clk) with auto-incrementing burst access to an
// internal RAM: opcode, address, then data words until SS_n rises.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OPC_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                miso,
  output logic                busy,
  output logic                err,
  output logic [ADDR_WIDTH:0] words_done
);

  localparam int SW = max3(OPC_WIDTH, ADDR_WIDTH, DATA_WIDTH);
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   WD_ONE   = 1;

  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [SW-2:0]           r_sin, w_sin_next;
  logic [DATA_WIDTH-1:0]   r_sout, w_sout_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [ADDR_WIDTH:0]     r_words, w_words_next;
  logic                    r_err, w_err_next;
  logic                    r_is_read, w_is_read_next;
  logic [SW-1:0]           w_shift_in;
  logic                    w_we, w_re;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic [ADDR_WIDTH:0]     w_words_inc;

  assign w_shift_in  = {r_sin, MOSI};
  assign w_words_inc = (r_words == '1) ? r_words : r_words + WD_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sin     <= '0;
      r_sout    <= '0;
      r_addr    <= '0;
      r_words   <= '0;
      r_err     <= 1'b0;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_sin     <= w_sin_next;
      r_sout    <= w_sout_next;
      r_addr    <= w_addr_next;
      r_words   <= w_words_next;
      r_err     <= w_err_next;
      r_is_read <= w_is_read_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_sin_next     = r_sin;
    w_sout_next    = r_sout;
    w_addr_next    = r_addr;
    w_words_next   = r_words;
    w_err_next     = 1'b0;
    w_is_read_next = r_is_read;
    w_we           = 1'b0;
    w_re           = 1'b0;

    if (SS_n) begin
      // Frame end; a half-received write word is dropped and flagged.
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_sout_next  = '0;
      w_err_next   = (r_state == WRITE) && (r_cnt != '0);
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = OPC;
          w_sin_next   = w_shift_in[SW-2:0];
          w_cnt_next   = CNT_ONE;
          w_words_next = '0;
          w_sout_next  = '0;
        end
        OPC: begin
          w_sin_next = w_shift_in[SW-2:0];
          if (r_cnt == CW'(OPC_WIDTH - 1)) begin
            w_cnt_next = '0;
            if (w_shift_in[OPC_WIDTH-1 -: 2] == OPC_WRITE) begin
              w_state_next   = ADDR;
              w_is_read_next = 1'b0;
            end else if (w_shift_in[OPC_WIDTH-1 -: 2] == OPC_READ) begin
              w_state_next   = ADDR;
              w_is_read_next = 1'b1;
            end else begin
              w_state_next = IGNORE;
              w_err_next   = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        ADDR: begin
          w_sin_next = w_shift_in[SW-2:0];
          if (r_cnt == CW'(ADDR_WIDTH - 1)) begin
            w_cnt_next   = '0;
            w_addr_next  = w_shift_in[ADDR_WIDTH-1:0];
            w_state_next = r_is_read ? RD_WAIT : WRITE;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        WRITE: begin
          w_sin_next = w_shift_in[SW-2:0];
          if (r_cnt == CW'(DATA_WIDTH - 1)) begin
            w_we         = 1'b1;
            w_cnt_next   = '0;
            w_addr_next  = r_addr + ADDR_ONE;
            w_words_next = w_words_inc;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        RD_WAIT: begin
          w_re = (r_cnt == '0);
          if (r_cnt == CW'(DUMMY_BITS - 1)) begin
            w_sout_next  = w_rdata;
            w_addr_next  = r_addr + ADDR_ONE;
            w_cnt_next   = '0;
            w_state_next = READ;
          end else begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        READ: begin
          // Prefetch one bit early so the next word follows without a gap.
          w_re = (r_cnt == CW'(DATA_WIDTH - 2));
          if (r_cnt == CW'(DATA_WIDTH - 1)) begin
            w_sout_next  = w_rdata;
            w_addr_next  = r_addr + ADDR_ONE;
            w_cnt_next   = '0;
            w_words_next = w_words_inc;
          end else begin
            w_sout_next = {r_sout[DATA_WIDTH-2:0], 1'b0};
            w_cnt_next  = r_cnt + CNT_ONE;
          end
        end
        IGNORE: begin
          w_sout_next = '0;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  spi_ram_sp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_en   ((w_we | w_re) & ~rst),
    .i_we   (w_we & ~rst),
    .i_addr (r_addr),
    .i_wdata(w_shift_in[DATA_WIDTH-1:0]),
    .o_rdata(w_rdata)
  );

  assign miso       = r_sout[DATA_WIDTH-1];
  assign busy       = (r_state != IDLE);
  assign err        = r_err;
  assign words_done = r_words;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: frames are bit-banged one clk per bit.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       miso, busy, err;
  logic [8:0] words_done;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_mark;
  logic [7:0] exp_w [0:3];

  always #5 clk = ~clk;

  spi_ram_burst dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .miso      (miso),
    .busy      (busy),
    .err       (err),
    .words_done(words_done)
  );

  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic step(input logic ss, input logic mosi);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, val[i]);
  endtask

  task automatic write_frame(input logic [7:0] addr, input int n);
    send(8'h00, 8);
    send(addr, 8);
    for (int w = 0; w < n; w++) send(exp_w[w], 8);
    step(1'b1, 1'b0);
    check("wr_words", 16'(words_done), 16'(n));
  endtask

  task automatic read_frame(input logic [7:0] addr, input int n);
    send(8'h40, 8);
    send(addr, 8);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int w = 0; w < n; w++) begin
      for (int b = 7; b >= 0; b--) begin
        check($sformatf("rd_a%0h_w%0d_b%0d", addr, w, b), 16'(miso), 16'(exp_w[w][b]));
        step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0);
    check("rd_words", 16'(words_done), 16'(n));
  endtask

  initial begin
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("rst_miso", 16'(miso), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_words", 16'(words_done), 16'h0);
    rst = 1'b0;
    step(1'b1, 1'b0);

    // Preload known contents
    exp_w[0] = 8'h5A; write_frame(8'h00, 1);
    exp_w[0] = 8'h3C; exp_w[1] = 8'hC3; write_frame(8'h20, 2);
    exp_w[0] = 8'h77; write_frame(8'h41, 1);

    // Reset with SS_n low and MOSI toggling must not start a frame or write
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i));
      check("rstf_busy", 16'(busy), 16'h0);
      check("rstf_miso", 16'(miso), 16'h0);
    end
    check("rstf_err", 16'(err), 16'h0);
    check("rstf_words", 16'(words_done), 16'h0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    exp_w[0] = 8'h5A; read_frame(8'h00, 1);

    // Single write then read
    exp_w[0] = 8'hA5; write_frame(8'h10, 1);
    read_frame(8'h10, 1);

    // Burst across the top of the address space
    err_mark = err_seen;
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33;
    write_frame(8'hFE, 3);
    read_frame(8'hFE, 3);
    exp_w[0] = 8'h33; read_frame(8'h00, 1);
    check("wrap_no_err", 16'(err_seen - err_mark), 16'h0);

    // Truncated word after 5 bits
    err_mark = err_seen;
    send(8'h00, 8); send(8'h20, 8); send(8'h15, 5);
    step(1'b1, 1'b0);
    check("trunc_err", 16'(err), 16'h1);
    check("trunc_busy", 16'(busy), 16'h0);
    step(1'b1, 1'b0);
    check("trunc_err_clr", 16'(err), 16'h0);
    check("trunc_pulses", 16'(err_seen - err_mark), 16'h1);

    // SS_n rises on the edge that would sample the LSB
    err_mark = err_seen;
    send(8'h00, 8); send(8'h21, 8); send(8'h7F, 7);
    step(1'b1, 1'b1);
    check("lsb_err", 16'(err), 16'h1);
    step(1'b1, 1'b0);
    check("lsb_pulses", 16'(err_seen - err_mark), 16'h1);
    exp_w[0] = 8'h3C; exp_w[1] = 8'hC3; read_frame(8'h20, 2);

    // Reserved opcode
    err_mark = err_seen;
    send(8'hC0, 8);
    check("rsv_err", 16'(err), 16'h1);
    check("rsv_busy", 16'(busy), 16'h1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'(i));
      check("rsv_miso", 16'(miso), 16'h0);
    end
    step(1'b1, 1'b0);
    check("rsv_pulses", 16'(err_seen - err_mark), 16'h1);
    exp_w[0] = 8'hA5; read_frame(8'h10, 1);

    // Reset during the second word of a write burst
    err_mark = err_seen;
    send(8'h00, 8); send(8'h40, 8); send(8'h99, 8); send(8'hEE, 4);
    rst = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("mid_busy", 16'(busy), 16'h0);
    check("mid_words", 16'(words_done), 16'h0);
    check("mid_miso", 16'(miso), 16'h0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("mid_no_err", 16'(err_seen - err_mark), 16'h0);
    exp_w[0] = 8'h99; exp_w[1] = 8'h77; read_frame(8'h40, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised SPI slave with an integrated synchronous single-port RAM. It extends the single-address-per-command SPI/RAM pair to configurable address and data widths and adds auto-incrementing burst reads and writes within one SS_n frame. It sits at chip top level between the SPI pins and on-chip storage. MOSI is sampled and MISO is driven on clk, with one SPI bit per clk cycle.

Parameters:
ADDR_WIDTH, 8, RAM address bits; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word width and SPI data word length
OPC_WIDTH, 8, opcode field length in bits

Ports:
clk  input  1  system clock; also the SPI bit clock
rst  input  1  synchronous reset, active-high
SS_n  input  1  slave select, active-low; a frame is the interval with SS_n low
MOSI  input  1  serial in, MSB first, sampled on rising clk while SS_n=0
miso  output  1  serial out, MSB first, registered
busy  output  1  high while a frame is in progress (state != IDLE)
err  output  1  one-cycle pulse on reserved opcode or truncated data word
words_done  output  ADDR_WIDTH+1  count of complete words transferred in the last or current frame

Behaviour:
- Reset: rst=1 at a rising edge forces state=IDLE. Reset values: miso=0, busy=0, err=0, words_done=0. RAM contents are not cleared. Reset mid-frame aborts the frame, and no further RAM write occurs.
- SS_n=1 at any edge: state returns to IDLE and miso=0. A partial word is discarded. If the partial word was a data word in WRITE, err pulses on the following cycle. words_done holds its value.
- States:
  - IDLE -> OPC on the first edge with SS_n=0. That edge samples opcode bit OPC_WIDTH-1. words_done clears to 0 at this point.
  - OPC: collects OPC_WIDTH bits. opcode[7:6]=00 is WRITE, 01 is READ, 1x is reserved. A reserved opcode goes to IGNORE and pulses err.
  - ADDR: collects ADDR_WIDTH bits into addr_reg.
  - WRITE: each DATA_WIDTH bits form one word. On the edge that samples the word's LSB, RAM[addr_reg] is written, addr_reg increments, and words_done increments.
  - RD_WAIT (2 cycles):
    - Edge A+1, where A is the edge sampling the last address bit: RAM read of addr_reg.
    - Edge A+2: shift register loaded, miso = word MSB, addr_reg increments.
    - The master treats these 2 bits as dummy.
  - READ: miso shifts one bit per edge. The RAM read for the next word is issued during the second-to-last bit. At the word boundary the next word loads with no gap bit. words_done increments on each word boundary.
  - IGNORE: MOSI is ignored and miso=0 until SS_n=1.
- Address wrap: addr_reg increments modulo DEPTH. DEPTH-1 -> 0 is silent, with no err.
- MOSI is ignored during READ/RD_WAIT.
- words_done saturates at 2**(ADDR_WIDTH+1)-1.
- Write during a frame, then read in a later frame: data is visible. There is no same-frame read-after-write.
- SS_n rise on the same edge as a WRITE LSB: SS_n has priority, so the word is not written and err pulses.

Decomposition:
- Shared package spi_ram_pkg holds:
  - state enum (IDLE, OPC, ADDR, WRITE, RD_WAIT, READ, IGNORE)
  - opcode constants OPC_WRITE=2'b00 and OPC_READ=2'b01
  - DUMMY_BITS=2
- One sub-module: spi_ram_sp, a synchronous single-port RAM with parameters ADDR_WIDTH and DATA_WIDTH, 1-cycle read latency, and write-first behaviour. The FSM and shift registers live in spi_ram_burst.

Test Plan:
- Reset: hold rst=1 for 3 cycles with SS_n=0 and MOSI toggling -> miso=0, busy=0, err=0, words_done=0; no RAM write to addr 0x00.
- Single write then read: frame WRITE, addr 0x10, data 0xA5; then frame READ, addr 0x10 -> after 2 dummy bits, miso serialises 1,0,1,0,0,1,0,1; words_done=1.
- Burst wrap: WRITE at addr 0xFE with data 0x11, 0x22, 0x33 -> RAM[0xFE]=0x11, RAM[0xFF]=0x22, RAM[0x00]=0x33, words_done=3, no err. READ burst from 0xFE returns 0x11, 0x22, 0x33 contiguously with no gap bits.
- Truncated word: WRITE at addr 0x20, 5 data bits, then SS_n=1 -> RAM[0x20] unchanged, err pulses exactly 1 cycle, busy=0 the next cycle.
- Reserved opcode 0xC0 followed by 16 MOSI bits -> err pulse after the 8th bit, miso=0 throughout, no RAM change.
- Reset mid-burst: rst=1 during the 2nd word of a WRITE burst at 0x40 -> RAM[0x40] holds the written value, RAM[0x41] unchanged, state=IDLE, words_done=0.
